img_proc_engine: RTL and testbench
==================================

Name: img_proc_engine

Overview:
Parametrised successor to the fixed shrink/effects pair: a single streaming engine that reads a stored image from the pixel ROM. It applies a run-time-selected down-sample factor and a run-time-selected per-pixel effect, and emits the result on a valid/ready stream. The stream feeds the output FIFO ahead of the UART transmitter. Channel count, channel width, image size and effect constant are parameters; mode and factor are latched per frame.

Parameters:
CH, 3, channels per pixel (must be >= 3)
CW, 8, bits per channel
HEIGHT, 30, source image rows
WIDTH, 30, source image columns
MAX_SHR, 2, max log2 down-sample factor (factors 1..2**MAX_SHR)
VALUE, 60, brightness step, unsigned CW bits
AW, $clog2(HEIGHT*WIDTH), ROM address width (derived)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request; sampled only in IDLE
mode  in  3  effect: 0 pass, 1 bright+, 2 bright-, 3 invert, 4 gray, 5-7 pass
shr  in  $clog2(MAX_SHR+1)  log2 down-sample factor
rom_en  out  1  ROM read strobe
rom_addr  out  AW  ROM read address
rom_data  in  CH*CW  ROM data, valid exactly 1 cycle after rom_en
pix_out  out  CH*CW  processed pixel; channel 0 in LSBs
pix_valid  out  1  pix_out valid
pix_ready  in  1  sink accepts when high with pix_valid
pix_last  out  1  high with the final pixel of the frame
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the last handshake

Behaviour:
- Reset: state IDLE. All outputs 0, counters 0.
- Clock and reset: one clock, clk; reset rst is synchronous and active-high. Reset overrides everything, including mid-frame and mid-handshake. The frame is abandoned and no done pulse is issued.
- start in IDLE latches mode and shr. shr > MAX_SHR is clamped to MAX_SHR. start while busy is ignored.
- Output size:
  - F = 1<<shr; OW = WIDTH>>shr; OH = HEIGHT>>shr.
  - Remainder rows/columns are dropped (30x30, F=4 gives 7x7).
  - If OW or OH is 0, go straight to DONE with no pixels.
- Down-sampling is decimation: the output pixel (ox,oy) takes source pixel (ox*F, oy*F). Address = oy*F*WIDTH + ox*F.
- Addressing is incremental: row_base += WIDTH<<shr and col_addr += F. No multiplier.
- FSM:
  - IDLE -> FETCH on start.
  - FETCH: rom_en=1 for 1 cycle -> WAIT.
  - WAIT: capture rom_data, apply effect into the output register -> SEND.
  - SEND: pix_valid=1, held stable until pix_ready. On handshake, either go to FETCH for the next pixel or, if last, go to DONE.
  - DONE: done=1 for 1 cycle, busy=0 -> IDLE.
- Latency and throughput: 3 cycles per pixel when the sink is always ready. pix_out, pix_valid and pix_last are registered.
- Backpressure: pix_out and pix_last are stable while pix_valid && !pix_ready. No ROM reads occur while stalled.
- Effects, per channel c (unsigned CW bits):
  - bright+: min(c+VALUE, 2**CW-1)
  - bright-: max(c-VALUE, 0)
  - invert: (2**CW-1)-c
  - gray: g = (c0 + 2*c1 + c2) >> 2, computed in CW+2 bits. g is written to channels 0..2; channels >= 3 pass through.
- pix_last is high only on the pixel with ox=OW-1 and oy=OH-1.
- busy is 1 in FETCH, WAIT and SEND; 0 in IDLE and DONE.

Decomposition:
- Package img_pkg: mode encodings (MODE_PASS..MODE_GRAY), the FSM state enum, and a pixel type with CH channels of CW bits.
- One sub-module: pix_effect, a combinational per-pixel effect unit (mode, pixel in -> pixel out), reused by other effect paths.

Test Plan:
- 4x4 ROM with value = address, CH=3, CW=8, mode 0, shr 1, sink always ready -> 4 pixels from addresses 0,2,8,10. pix_last on the 4th. done 1 cycle after the 4th handshake; 3 cycles per pixel.
- mode 1, VALUE 60, channels {250,100,0} -> {255,160,60}. mode 2 on the same pixel -> {190,40,0}. mode 3 -> {5,155,255}.
- mode 4, channels {10,20,30} -> g=(10+40+30)>>2=20, output {20,20,20}.
- 30x30, shr 2 -> 49 pixels. Last address = 24*30+24 = 744. shr 3 is clamped to 2 with identical output.
- pix_ready low for 5 cycles mid-frame -> pix_out stable, no rom_en pulses. Frame contents are unchanged.
- rst asserted in SEND -> next cycle all outputs 0, no done. A new start runs a full correct frame. start while busy -> ignored.

Source files
------------

// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared encodings and types for the image processing engine
// Contents: effect mode codes, engine FSM state enum, default pixel type.
package img_pkg;

    // Effect selection; codes 5..7 fall back to pass-through.
    localparam logic [2:0] MODE_PASS      = 3'd0;
    localparam logic [2:0] MODE_BRIGHT_UP = 3'd1;
    localparam logic [2:0] MODE_BRIGHT_DN = 3'd2;
    localparam logic [2:0] MODE_INVERT    = 3'd3;
    localparam logic [2:0] MODE_GRAY      = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_SEND,
        ST_DONE
    } state_e;

    // Default pixel geometry; channel 0 sits in the LSBs when flattened.
    localparam int PIX_CH = 3;
    localparam int PIX_CW = 8;
    typedef logic [PIX_CH-1:0][PIX_CW-1:0] pixel_t;

endpackage

// File: rtl/img_proc_engine_pix_effect.sv
// rtl/img_proc_engine_pix_effect.sv - combinational per-pixel effect unit
// Ports: i_mode (effect select), i_pix (CH*CW input pixel, channel 0 in LSBs),
//        o_pix (CH*CW processed pixel).
module pix_effect
    import img_pkg::*;
#(
    parameter int CH    = 3,
    parameter int CW    = 8,
    parameter int VALUE = 60
) (
    input  logic [2:0]       i_mode,
    input  logic [CH*CW-1:0] i_pix,
    output logic [CH*CW-1:0] o_pix
);

    localparam logic [CW-1:0] VAL  = CW'(VALUE);
    localparam logic [CW-1:0] MAXV = '1;

    // Weighted luma (c0 + 2*c1 + c2) / 4 needs two extra bits before the shift.
    logic [CW+1:0] w_gsum;
    logic [CW-1:0] w_gray;

    assign w_gsum = {2'b00, i_pix[0 +: CW]}
                  + {1'b0, i_pix[CW +: CW], 1'b0}
                  + {2'b00, i_pix[2*CW +: CW]};
    assign w_gray = CW'(w_gsum >> 2);

    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic [CW-1:0] w_c;
        logic [CW-1:0] w_o;
        logic [CW:0]   w_sum;

        assign w_c   = i_pix[g*CW +: CW];
        assign w_sum = {1'b0, w_c} + {1'b0, VAL};

        always_comb begin
            w_o = w_c;
            case (i_mode)
                MODE_BRIGHT_UP: w_o = w_sum[CW] ? MAXV : w_sum[CW-1:0];
                MODE_BRIGHT_DN: w_o = (w_c > VAL) ? (w_c - VAL) : '0;
                MODE_INVERT:    w_o = MAXV - w_c;
                MODE_GRAY:      if (g < 3) w_o = w_gray;
                default:        w_o = w_c;
            endcase
        end

        assign o_pix[g*CW +: CW] = w_o;
    end

endmodule

// File: rtl/img_proc_engine.sv
// rtl/img_proc_engine.sv - streaming ROM image reader with decimation and per-pixel effect
// Ports: clk/rst (sync active-high), start/mode/shr (frame request, latched in IDLE),
//        rom_en/rom_addr/rom_data (1-cycle latency ROM), pix_out/pix_valid/pix_ready/pix_last
//        (output stream), busy/done (frame status).
module img_proc_engine
    import img_pkg::*;
#(
    parameter int CH      = 3,
    parameter int CW      = 8,
    parameter int HEIGHT  = 30,
    parameter int WIDTH   = 30,
    parameter int MAX_SHR = 2,
    parameter int VALUE   = 60,
    parameter int AW      = $clog2(HEIGHT*WIDTH),
    parameter int SW      = $clog2(MAX_SHR+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [SW-1:0]    shr,
    output logic             rom_en,
    output logic [AW-1:0]    rom_addr,
    input  logic [CH*CW-1:0] rom_data,
    output logic [CH*CW-1:0] pix_out,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             pix_last,
    output logic             busy,
    output logic             done
);

    localparam int XW = $clog2(WIDTH+1);
    localparam int YW = $clog2(HEIGHT+1);

    state_e          r_state;
    logic [2:0]      r_mode;
    logic [SW-1:0]   r_shr;
    logic [XW-1:0]   r_ox;
    logic [YW-1:0]   r_oy;
    logic [AW-1:0]   r_row_base;

    logic [SW-1:0]    w_shr_c;
    logic [SW-1:0]    w_shr_sel;
    logic [XW-1:0]    w_ow;
    logic [YW-1:0]    w_oh;
    logic [AW-1:0]    w_step;
    logic [AW-1:0]    w_row_next;
    logic             w_last;
    logic [CH*CW-1:0] w_eff;

    assign w_shr_c = (int'(shr) > MAX_SHR) ? SW'(MAX_SHR) : shr;

    // In IDLE the output size is judged from the incoming request so an
    // empty frame can go straight to DONE; otherwise from the latched factor.
    assign w_shr_sel  = (r_state == ST_IDLE) ? w_shr_c : r_shr;
    assign w_ow       = XW'(WIDTH >> w_shr_sel);
    assign w_oh       = YW'(HEIGHT >> w_shr_sel);
    assign w_step     = AW'(1) << r_shr;
    assign w_row_next = r_row_base + AW'(WIDTH << r_shr);
    assign w_last     = (r_ox == w_ow - XW'(1)) && (r_oy == w_oh - YW'(1));

    pix_effect #(
        .CH    (CH),
        .CW    (CW),
        .VALUE (VALUE)
    ) u_effect (
        .i_mode (r_mode),
        .i_pix  (rom_data),
        .o_pix  (w_eff)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_mode     <= '0;
            r_shr      <= '0;
            r_ox       <= '0;
            r_oy       <= '0;
            r_row_base <= '0;
            rom_en     <= 1'b0;
            rom_addr   <= '0;
            pix_out    <= '0;
            pix_valid  <= 1'b0;
            pix_last   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mode     <= mode;
                        r_shr      <= w_shr_c;
                        r_ox       <= '0;
                        r_oy       <= '0;
                        r_row_base <= '0;
                        rom_addr   <= '0;
                        if (w_ow == '0 || w_oh == '0) begin
                            r_state <= ST_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state <= ST_FETCH;
                            rom_en  <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    rom_en  <= 1'b0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    pix_out   <= w_eff;
                    pix_valid <= 1'b1;
                    pix_last  <= w_last;
                    r_state   <= ST_SEND;
                end
                ST_SEND: begin
                    if (pix_ready) begin
                        pix_valid <= 1'b0;
                        pix_last  <= 1'b0;
                        if (w_last) begin
                            r_state <= ST_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            r_state <= ST_FETCH;
                            rom_en  <= 1'b1;
                            if (r_ox == w_ow - XW'(1)) begin
                                r_ox       <= '0;
                                r_oy       <= r_oy + YW'(1);
                                r_row_base <= w_row_next;
                                rom_addr   <= w_row_next;
                            end else begin
                                r_ox     <= r_ox + XW'(1);
                                rom_addr <= rom_addr + w_step;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_img_proc_engine.sv
// tb/tb_img_proc_engine.sv - directed self-checking bench for img_proc_engine
module tb_img_proc_engine;
    import img_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Instance A: 4x4 image, factors up to 8 so an empty frame is reachable.
    logic        rst_a, start_a, rom_en_a, pix_valid_a, pix_ready_a, pix_last_a, busy_a, done_a;
    logic [2:0]  mode_a;
    logic [1:0]  shr_a;
    logic [3:0]  rom_addr_a;
    logic [23:0] rom_data_a = '0;
    logic [23:0] pix_out_a;
    logic [23:0] rom_a [16];

    img_proc_engine #(
        .CH(3), .CW(8), .HEIGHT(4), .WIDTH(4), .MAX_SHR(3), .VALUE(60)
    ) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .mode(mode_a), .shr(shr_a),
        .rom_en(rom_en_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
        .pix_out(pix_out_a), .pix_valid(pix_valid_a), .pix_ready(pix_ready_a),
        .pix_last(pix_last_a), .busy(busy_a), .done(done_a)
    );

    // Instance B: 30x30 image, default parameters.
    logic        rst_b, start_b, rom_en_b, pix_valid_b, pix_ready_b, pix_last_b, busy_b, done_b;
    logic [2:0]  mode_b;
    logic [1:0]  shr_b;
    logic [9:0]  rom_addr_b;
    logic [23:0] rom_data_b = '0;
    logic [23:0] pix_out_b;
    logic [23:0] rom_b [1024];

    img_proc_engine #(
        .CH(3), .CW(8), .HEIGHT(30), .WIDTH(30), .MAX_SHR(2), .VALUE(60)
    ) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .mode(mode_b), .shr(shr_b),
        .rom_en(rom_en_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
        .pix_out(pix_out_b), .pix_valid(pix_valid_b), .pix_ready(pix_ready_b),
        .pix_last(pix_last_b), .busy(busy_b), .done(done_b)
    );

    // ROM models: data appears one cycle after the read strobe.
    always @(posedge clk) begin
        if (rom_en_a) rom_data_a <= rom_a[rom_addr_a];
        if (rom_en_b) rom_data_b <= rom_b[rom_addr_b];
    end

    // Stream and status monitors.
    logic [23:0] q_a[$], q_b[$];
    bit          l_a[$], l_b[$];
    int          t_a[$];
    int done_n_a = 0, done_t_a = 0, en_n_a = 0, done_n_b = 0, en_n_b = 0;

    always @(posedge clk) begin
        if (pix_valid_a && pix_ready_a) begin
            q_a.push_back(pix_out_a); l_a.push_back(pix_last_a); t_a.push_back(cyc);
        end
        if (done_a) begin done_n_a++; done_t_a = cyc; end
        if (rom_en_a) en_n_a++;
        if (pix_valid_b && pix_ready_b) begin
            q_b.push_back(pix_out_b); l_b.push_back(pix_last_b);
        end
        if (done_b) done_n_b++;
        if (rom_en_b) en_n_b++;
        cyc++;
    end

    int pA, dA, eA, sA, pB, dB;

    task automatic run_a(input logic [2:0] m, input logic [1:0] s);
        pA = q_a.size(); dA = done_n_a; eA = en_n_a;
        @(negedge clk);
        mode_a = m; shr_a = s; start_a = 1'b1; sA = cyc;
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 300 && done_n_a == dA; i++) @(negedge clk);
        chk("a_done_seen", done_n_a - dA, 1);
        @(negedge clk);
    endtask

    task automatic eff_a(input string tag, input logic [2:0] m, input logic [23:0] exp);
        run_a(m, 2'd2);
        chk({tag, "_count"}, q_a.size() - pA, 1);
        chk({tag, "_pix"}, q_a[pA], exp);
        chk({tag, "_last"}, l_a[pA], 1);
    endtask

    task automatic start_b_req(input logic [2:0] m, input logic [1:0] s);
        pB = q_b.size(); dB = done_n_b;
        @(negedge clk);
        mode_b = m; shr_b = s; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
    endtask

    task automatic wait_done_b();
        for (int i = 0; i < 1000 && done_n_b == dB; i++) @(negedge clk);
        chk("b_done_seen", done_n_b - dB, 1);
        @(negedge clk);
    endtask

    task automatic check_b_frame(input string tag);
        int lasts;
        int a;
        lasts = 0;
        chk({tag, "_count"}, q_b.size() - pB, 49);
        for (int i = 0; i < 49; i++) begin
            a = (i / 7) * 120 + (i % 7) * 4;
            chk({tag, "_pix"}, q_b[pB+i], {8'h5A, 8'(a >> 8), 8'(a)});
            if (l_b[pB+i]) lasts++;
        end
        chk({tag, "_last_pos"}, l_b[pB+48], 1);
        chk({tag, "_last_cnt"}, lasts, 1);
    endtask

    logic [23:0] snap;
    int          en_snap;
    int          exp_addr [4];
    pixel_t      px;

    initial begin
        rst_a = 1; rst_b = 1; start_a = 0; start_b = 0;
        mode_a = 0; mode_b = 0; shr_a = 0; shr_b = 0;
        pix_ready_a = 1; pix_ready_b = 1;
        for (int i = 0; i < 16; i++) rom_a[i] = {3{8'(i)}};
        for (int i = 0; i < 1024; i++) rom_b[i] = {8'h5A, 8'(i >> 8), 8'(i)};
        repeat (3) @(negedge clk);

        chk("rst_valid", pix_valid_a, 0);
        chk("rst_out", pix_out_a, 0);
        chk("rst_last", pix_last_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_rom_en", rom_en_a, 0);
        chk("rst_rom_addr", rom_addr_a, 0);
        rst_a = 0; rst_b = 0;

        // 4x4, factor 2: addresses 0,2,8,10 at 3 cycles per pixel.
        run_a(3'd0, 2'd1);
        exp_addr = '{0, 2, 8, 10};
        chk("dec_count", q_a.size() - pA, 4);
        for (int i = 0; i < 4; i++) begin
            chk("dec_pix", q_a[pA+i], {3{8'(exp_addr[i])}});
            chk("dec_last", l_a[pA+i], (i == 3) ? 1 : 0);
        end
        chk("dec_first_lat", t_a[pA] - sA, 3);
        for (int i = 0; i < 3; i++) chk("dec_rate", t_a[pA+i+1] - t_a[pA+i], 3);
        chk("dec_done_lat", done_t_a - t_a[pA+3], 1);
        chk("dec_busy_after", busy_a, 0);

        // Effects on a single-pixel frame (4x4, factor 4).
        px[0] = 8'd250; px[1] = 8'd100; px[2] = 8'd0;
        rom_a[0] = px;
        eff_a("bright_up", 3'd1, 24'h3CA0FF);
        eff_a("bright_dn", 3'd2, 24'h0028BE);
        eff_a("invert",    3'd3, 24'hFF9B05);
        px[0] = 8'd10; px[1] = 8'd20; px[2] = 8'd30;
        rom_a[0] = px;
        eff_a("gray",      3'd4, 24'h141414);
        eff_a("mode6",     3'd6, 24'h1E140A);

        // Factor 8 on a 4x4 image: no pixels, no ROM reads, still done.
        run_a(3'd0, 2'd3);
        chk("empty_count", q_a.size() - pA, 0);
        chk("empty_rom", en_n_a - eA, 0);

        // 30x30 factor 4 with a 5-cycle stall on the 4th pixel.
        start_b_req(3'd0, 2'd2);
        for (int i = 0; i < 300 && (q_b.size() - pB) < 3; i++) @(negedge clk);
        for (int i = 0; i < 10 && !pix_valid_b; i++) @(negedge clk);
        chk("stall_valid_pre", pix_valid_b, 1);
        pix_ready_b = 0;
        snap = pix_out_b; en_snap = en_n_b;
        chk("stall_pix", snap, 24'h5A000C);
        repeat (5) begin
            @(negedge clk);
            chk("stall_out", pix_out_b, 24'h5A000C);
            chk("stall_hold", pix_valid_b, 1);
        end
        chk("stall_no_rom", en_n_b - en_snap, 0);
        chk("stall_busy", busy_b, 1);
        pix_ready_b = 1;
        wait_done_b();
        check_b_frame("stall");

        // shr 3 clamps to 2: same 49-pixel frame.
        start_b_req(3'd0, 2'd3);
        wait_done_b();
        check_b_frame("clamp");

        // Reset while a pixel waits in SEND.
        pix_ready_b = 0;
        start_b_req(3'd0, 2'd2);
        for (int i = 0; i < 20 && !pix_valid_b; i++) @(negedge clk);
        rst_b = 1;
        @(negedge clk);
        chk("mrst_valid", pix_valid_b, 0);
        chk("mrst_out", pix_out_b, 0);
        chk("mrst_last", pix_last_b, 0);
        chk("mrst_busy", busy_b, 0);
        chk("mrst_rom_en", rom_en_b, 0);
        rst_b = 0;
        repeat (10) @(negedge clk);
        chk("mrst_no_done", done_n_b - dB, 0);
        pix_ready_b = 1;

        // Fresh frame after reset; a start while busy must be ignored.
        start_b_req(3'd0, 2'd2);
        repeat (10) @(negedge clk);
        mode_b = 3'd3; shr_b = 2'd1; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        wait_done_b();
        check_b_frame("restart");
        repeat (10) @(negedge clk);
        chk("restart_no_extra", q_b.size() - pB, 49);
        chk("restart_one_done", done_n_b - dB, 1);
        chk("restart_idle", busy_b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
